uart_word_rx: RTL and testbench
===============================

# uart_word_rx

Synthesizable UART receiver on the FPGA side of the host serial link. It decodes 8N1 frames (start 0, data LSB-first, stop 1) and pairs consecutive bytes into 16-bit words, with the first byte received forming the MSB. Each completed word is delivered through a one-word valid/ready output register. Framing and overrun errors are reported as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per bit (50 MHz at 57600 baud); must be at least 4.
- `TIMEOUT_BITS`, default 32: inter-byte timeout in bit periods; used only with `UART_RX_TIMEOUT_EN`.
- `clk` input, 1 bit: single clock; all logic on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `rx` input, 1 bit: serial line, asynchronous to `clk`; idles high.
- `word_data` output, 16 bits: received word, `{first byte, second byte}`.
- `word_valid` output, 1 bit: `word_data` holds an unconsumed word.
- `word_ready` input, 1 bit: consumer accepts the word.
- `frame_err` output, 1 bit: one-cycle pulse when a stop bit is sampled low.
- `overrun` output, 1 bit: one-cycle pulse when a completed word is dropped.
- `busy` output, 1 bit: high while the FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1) to give `rx_s`.
- A start is detected on a falling edge of `rx_s` (previous 1, current 0). A line held low never re-triggers.
- FSM states and transitions:
  - IDLE: a falling edge goes to START and clears the bit-period counter.
  - START: at count `CLKS_PER_BIT/2` (integer division), if `rx_s`=1 it is a false start and the FSM returns to IDLE with no error. Otherwise it goes to DATA.
  - DATA: samples every `CLKS_PER_BIT` cycles into shift bit i, for i=0..7, then goes to STOP.
  - STOP: samples one period after bit 7.
    - If `rx_s`=1, the byte is good.
    - If `rx_s`=0, `frame_err` pulses, the byte is discarded, the pending MSB is discarded, and the FSM goes to IDLE.
- Word assembly:
  - A `phase` flag is 0 while awaiting the MSB byte.
  - A good byte with phase=0 is stored as the MSB and sets phase=1.
  - A good byte with phase=1 completes the word and clears phase.
- Output register behaviour on word completion:
  - If `word_valid`=0, or the handshake (`word_valid & word_ready`) occurs in the same cycle, the register loads the new word and `word_valid`=1.
  - Otherwise the new word is dropped, `overrun` pulses, and the held word is unchanged.
- A handshake without a new word clears `word_valid` on the next cycle.
- `word_data` is stable while `word_valid`=1.
- Reset, asynchronous and usable mid-frame:
  - FSM to IDLE, phase=0, synchronizer flops to 1.
  - Outputs: `word_data`=0, `word_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0.
  - A partial frame in progress is lost. Reception resumes only at the next falling edge after release.

## Timing
- Let E be the cycle in which `rx_s` first shows 0 (2–3 cycles after the `rx` edge).
- The start bit is checked at E+`CLKS_PER_BIT/2`.
- Data bit i is sampled at E+`CLKS_PER_BIT/2`+(i+1)·`CLKS_PER_BIT`.
- The stop bit is sampled at E+`CLKS_PER_BIT/2`+9·`CLKS_PER_BIT`.
- `word_valid`, `frame_err` and `overrun` are registered and assert on the cycle after the stop sample.
- The FSM is back in IDLE on the cycle after the stop sample, so back-to-back frames with zero idle time are received.
- Baud tolerance is ±4% total mismatch.
- Bit-period counter width is `$clog2(CLKS_PER_BIT)`.

## Configuration
- `UART_RX_TIMEOUT_EN` defined:
  - An inter-byte counter runs while phase=1 and the FSM is in IDLE.
  - When it reaches `TIMEOUT_BITS`·`CLKS_PER_BIT` cycles, phase clears and the stored MSB is discarded silently.
  - Any falling edge resets the counter.
- `UART_RX_TIMEOUT_EN` undefined: phase persists indefinitely and the counter logic is absent.

## Structure
- Shared package `uart_pkg` holds:
  - `UART_START` = 1'b0 and `UART_STOP` = 1'b1;
  - the FSM state typedef (IDLE, START, DATA, STOP);
  - the function computing the half-bit count.
- Sub-module `uart_rx_sync`: 2-flop synchronizer plus falling-edge detector. Outputs are `rx_s` and `fall`; it takes the same `clk` and `rst`.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 for simulation unless stated otherwise.
- Send bytes 8'h00 then 8'hDE with `word_ready`=1 → one `word_valid` pulse, `word_data`=16'h00DE, no errors.
- Send 16'hA55A and 16'h1234 back-to-back with `word_ready`=0 → first word held as 16'hA55A, `overrun` pulses once at completion of 16'h1234. Raising `word_ready` then consumes 16'hA55A and `word_valid` drops.
- Hold the stop bit of the first byte low → `frame_err` pulses and no word is produced. A following good pair 8'h12, 8'h34 yields 16'h1234, proving phase was reset.
- A 5-cycle low glitch on `rx` → no state beyond START, `busy` returns low within 10 cycles, no outputs.
- Assert `rst` during bit 4 of the second byte of 16'hBEEF → all outputs 0. After release, sending 16'hCAFE yields exactly 16'hCAFE.
- With `UART_RX_TIMEOUT_EN` and `TIMEOUT_BITS`=4: send 8'h11, idle 5 bit periods, then send 8'h22, 8'h33 → `word_data`=16'h2233. Without the macro, the same stimulus gives 16'h1122.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART word receiver: line levels
//               for start/stop bits, the receive FSM state type and the
//               half-bit sample offset helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic UART_START = 1'b0;
    localparam logic UART_STOP  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Offset from the start edge to the middle of the start bit.
    function automatic int unsigned half_bit_count(input int unsigned clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizer for the asynchronous serial input plus
//               a falling-edge detector on the synchronized line.
// Ports       : clk  - clock
//               rst  - asynchronous active-high reset
//               rx   - raw serial input (idles high)
//               rx_s - synchronized serial line
//               fall - one-cycle pulse: rx_s was 1 last cycle and is 0 now
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // All flops reset to the idle level so release of reset never looks
    // like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= UART_STOP;
            r_sync <= UART_STOP;
            r_prev <= UART_STOP;
        end else begin
            r_meta <= rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rx_s = r_sync;
    assign fall = r_prev & ~r_sync;

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_word_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_rx
// Description : 8N1 UART receiver that pairs consecutive bytes into 16-bit
//               words (first byte = MSB) and presents them through a
//               one-word valid/ready output register.
// Parameters  : CLKS_PER_BIT - clock cycles per bit (>= 4)
//               TIMEOUT_BITS - inter-byte timeout in bit periods
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               rx            - serial input
//               word_data     - received word {first byte, second byte}
//               word_valid    - word_data holds an unconsumed word
//               word_ready    - consumer accepts the word
//               frame_err     - pulse: stop bit sampled low
//               overrun       - pulse: completed word dropped
//               busy          - receive FSM not idle
// Options     : define UART_RX_TIMEOUT_EN to discard a lone MSB byte after
//               TIMEOUT_BITS idle bit periods.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_word_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned TIMEOUT_BITS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [15:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

    localparam int unsigned c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned c_HALF  = half_bit_count(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(c_HALF - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
        $error("uart_word_rx: CLKS_PER_BIT must be at least 4");
    end
    if (TIMEOUT_BITS < 1) begin : g_bad_timeout_bits
        $error("uart_word_rx: TIMEOUT_BITS must be at least 1");
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int unsigned c_TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned c_TO_W   = (c_TO_CYC > 1) ? $clog2(c_TO_CYC) : 1;
    localparam logic [c_TO_W-1:0] c_TO_M1  = c_TO_W'(c_TO_CYC - 1);
    localparam logic [c_TO_W-1:0] c_TO_ONE = c_TO_W'(1);
    logic [c_TO_W-1:0] r_to_cnt;
`endif

    logic w_rx_s;
    logic w_fall;

    uart_state_t        r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_phase;
    logic [7:0]         r_msb;
    logic [15:0]        r_word_data;
    logic               r_word_valid;
    logic               r_frame_err;
    logic               r_overrun;
    logic               r_busy;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (w_rx_s),
        .fall (w_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_phase      <= 1'b0;
            r_msb        <= '0;
            r_word_data  <= '0;
            r_word_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
            r_to_cnt     <= '0;
`endif
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;

            // Consumption; overridden below if a new word loads this cycle.
            if (r_word_valid && word_ready) begin
                r_word_valid <= 1'b0;
            end

`ifdef UART_RX_TIMEOUT_EN
            // Only counts while a lone MSB waits in IDLE; any start edge
            // restarts the wait.
            if (w_fall || !(r_phase && (r_state == IDLE))) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt == c_TO_M1) begin
                r_to_cnt <= '0;
                r_phase  <= 1'b0;
            end else begin
                r_to_cnt <= r_to_cnt + c_TO_ONE;
            end
`endif

            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state <= START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                START: begin
                    if (r_cnt == c_HALF_M1) begin
                        r_cnt <= '0;
                        if (w_rx_s == UART_STOP) begin
                            // Line back high at mid start bit: glitch.
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                DATA: begin
                    if (r_cnt == c_FULL_M1) begin
                        r_cnt   <= '0;
                        // LSB first: shift in from the top.
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                STOP: begin
                    if (r_cnt == c_FULL_M1) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        if (w_rx_s == UART_STOP) begin
                            if (!r_phase) begin
                                r_msb   <= r_shift;
                                r_phase <= 1'b1;
                            end else begin
                                r_phase <= 1'b0;
                                if (!r_word_valid || word_ready) begin
                                    r_word_data  <= {r_msb, r_shift};
                                    r_word_valid <= 1'b1;
                                end else begin
                                    r_overrun <= 1'b1;
                                end
                            end
                        end else begin
                            // Bad frame also drops any pending MSB so the
                            // next good byte starts a fresh word.
                            r_frame_err <= 1'b1;
                            r_phase     <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign word_data  = r_word_data;
    assign word_valid = r_word_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = r_busy;

endmodule : uart_word_rx
`default_nettype wire

// File: tb/tb_uart_word_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_word_rx
// Description : Self-checking bench for uart_word_rx. Drives serial frames,
//               keeps a byte-level model of word pairing, and compares the
//               words handed over by the DUT with the model's words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_word_rx;

    localparam int CPB = 16;
    localparam int TOB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic        word_ready = 1'b0;
    logic [15:0] word_data;
    logic        word_valid;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    uart_word_rx #(
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    int fe_cnt = 0;
    int ov_cnt = 0;
    int exp_fe = 0;
    int exp_ov = 0;

    bit         m_phase = 1'b0;
    logic [7:0] m_msb   = 8'h00;

    // Observe handshakes and pulses away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (word_valid && word_ready) got_q.push_back(word_data);
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte-level reference: pairs good bytes, a bad frame forgets the MSB.
    function automatic void model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            m_phase = 1'b0;
            exp_fe++;
        end else if (!m_phase) begin
            m_msb   = b;
            m_phase = 1'b1;
        end else begin
            exp_q.push_back({m_msb, b});
            m_phase = 1'b0;
        end
    endfunction

    task automatic wait_bit();
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_bit);
        rx = 1'b0;
        wait_bit();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_bit();
        end
        rx = stop_bit;
        wait_bit();
        rx = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b);
        send_byte(b, 1'b1);
        model_byte(b, 1'b1);
    endtask

    task automatic compare_queues(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_word%0d", tag, i), {16'h0, got_q[i]}, {16'h0, exp_q[i]});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bit   saw_busy;
        int   n;
        logic [7:0] b;
        bit   good;
        int   gap;

        // Reset state
        wait_cycles(3);
        check("rst_word_data", {16'h0, word_data}, 32'h0);
        check("rst_word_valid", {31'h0, word_valid}, 32'h0);
        check("rst_frame_err", {31'h0, frame_err}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        rst = 1'b0;
        wait_cycles(4);

        // Basic word, consumer always ready
        word_ready = 1'b1;
        send_good(8'h00);
        send_good(8'hDE);
        wait_cycles(4);
        compare_queues("t1");
        check("t1_frame_err", fe_cnt, exp_fe);

        // Back-pressure: second word overruns
        word_ready = 1'b0;
        send_good(8'hA5);
        send_good(8'h5A);
        send_good(8'h12);
        send_good(8'h34);
        void'(exp_q.pop_back());
        exp_ov++;
        wait_cycles(3);
        check("t2_valid_held", {31'h0, word_valid}, 32'h1);
        check("t2_data_held", {16'h0, word_data}, 32'hA55A);
        check("t2_overrun", ov_cnt, exp_ov);
        word_ready = 1'b1;
        wait_cycles(1);
        check("t2_valid_drop", {31'h0, word_valid}, 32'h0);
        compare_queues("t2");

        // Bad stop on first byte, then a good pair
        send_byte(8'h77, 1'b0);
        model_byte(8'h77, 1'b0);
        wait_cycles(3);
        send_good(8'h12);
        send_good(8'h34);
        wait_cycles(4);
        check("t3_frame_err", fe_cnt, exp_fe);
        compare_queues("t3");

        // Bad stop after a pending MSB must forget that MSB
        send_good(8'h99);
        send_byte(8'h77, 1'b0);
        model_byte(8'h77, 1'b0);
        wait_cycles(3);
        send_good(8'h56);
        send_good(8'h78);
        wait_cycles(4);
        check("t3b_frame_err", fe_cnt, exp_fe);
        compare_queues("t3b");

        // Short glitch: start aborted, nothing produced
        saw_busy = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_cycles(1);
            if (busy) saw_busy = 1'b1;
        end
        rx = 1'b1;
        n = 0;
        while (n < 10) begin
            wait_cycles(1);
            if (busy) saw_busy = 1'b1;
            else if (saw_busy) break;
            n++;
        end
        check("t4_busy_seen", {31'h0, saw_busy}, 32'h1);
        check("t4_busy_low", {31'h0, busy}, 32'h0);
        wait_cycles(CPB * 2);
        check("t4_no_frame_err", fe_cnt, exp_fe);
        compare_queues("t4");

        // Reset in the middle of the second byte of BEEF
        send_good(8'hBE);
        rx = 1'b0;
        wait_bit();
        for (int i = 0; i < 4; i++) begin
            b = 8'hEF;
            rx = b[i];
            wait_bit();
        end
        b = 8'hEF;
        rx = b[4];
        repeat (CPB / 2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_word_data", {16'h0, word_data}, 32'h0);
        check("t5_rst_word_valid", {31'h0, word_valid}, 32'h0);
        check("t5_rst_frame_err", {31'h0, frame_err}, 32'h0);
        check("t5_rst_overrun", {31'h0, overrun}, 32'h0);
        check("t5_rst_busy", {31'h0, busy}, 32'h0);
        m_phase = 1'b0;
        rx = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(4);
        send_good(8'hCA);
        send_good(8'hFE);
        wait_cycles(4);
        compare_queues("t5");

        // Lone MSB followed by a long idle gap
        send_good(8'h11);
        wait_cycles(5 * CPB);
`ifdef UART_RX_TIMEOUT_EN
        m_phase = 1'b0;
`endif
        send_good(8'h22);
        send_good(8'h33);
        wait_cycles(4);
        compare_queues("t6");

        // Random byte stream with occasional framing errors
        for (int k = 0; k < 24; k++) begin
            b    = 8'($urandom);
            good = ($urandom_range(0, 7) != 0);
            send_byte(b, good);
            model_byte(b, good);
            gap = good ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 5));
            wait_cycles(gap);
        end
        wait_cycles(4);
        compare_queues("t7");
        check("t7_frame_err", fe_cnt, exp_fe);
        check("t7_overrun", ov_cnt, exp_ov);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_uart_word_rx
`default_nettype wire
